// File: rtl/bp_fe_queue_rollback.sv
// ============================================================================
// Module      : bp_fe_queue_rollback
// Description : FE queue with speculative read pointer, commit pointer and
//               rollback of issued-but-uncommitted entries.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_fe_queue_rollback #(
  parameter int els_p   = 8,
  parameter int width_p = 64
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clr_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i,
  input  logic               deq_i,
  input  logic               roll_i,
  output logic               empty_o
);

  localparam int                 C_IDX_W = $clog2(els_p);
  localparam int                 C_PTR_W = C_IDX_W + 1;
  localparam logic [C_PTR_W-1:0] C_ONE   = C_PTR_W'(1);
  localparam logic [C_PTR_W-1:0] C_ELS   = C_PTR_W'(els_p);

  logic [width_p-1:0] r_mem [els_p];
  logic [C_PTR_W-1:0] r_wptr, r_rptr, r_cptr;
  logic [C_PTR_W-1:0] w_wptr_inc;
  logic [C_PTR_W-1:0] w_occ;
  logic               w_full;
  logic               w_enq;

  // Pointers carry a wrap bit, so plain subtraction yields occupancy 0..els_p.
  assign w_wptr_inc = r_wptr + C_ONE;
  assign w_occ      = r_wptr - r_cptr;
  assign w_full     = (w_occ == C_ELS);
  assign w_enq      = v_i & ready_o;

  assign ready_o = ~w_full & ~clr_i;
  assign v_o     = (r_rptr != r_wptr);
  assign empty_o = (r_wptr == r_cptr);
  assign data_o  = r_mem[r_rptr[C_IDX_W-1:0]];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cptr <= '0;
    end else if (clr_i) begin
      // Flush lands all pointers one past the write pointer; storage untouched.
      r_wptr <= w_wptr_inc;
      r_rptr <= w_wptr_inc;
      r_cptr <= w_wptr_inc;
    end else begin
      if (w_enq) r_wptr <= w_wptr_inc;
      if (roll_i) begin
        r_rptr <= r_cptr;
      end else begin
        if (yumi_i) r_rptr <= r_rptr + C_ONE;
        if (deq_i)  r_cptr <= r_cptr + C_ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wptr[C_IDX_W-1:0]] <= data_i;
  end

`ifndef SYNTHESIS
  a_yumi_valid : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    yumi_i |-> v_o);
  a_deq_issued : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    deq_i |-> (r_cptr != r_rptr));
  a_ctl_in_reset : assert property (@(posedge clk_i)
    !reset_n_i |-> !(roll_i | clr_i));
`endif

endmodule

`default_nettype wire

// File: doc/bp_fe_queue_rollback.md
BP_FE_QUEUE_ROLLBACK -- requirements
Module: bp_fe_queue_rollback

Interface
REQ-001 The block SHALL have parameter els_p, default 8, giving entry count; it must be a power of two and at least 2.
REQ-002 The block SHALL have parameter width_p, default 64, giving the FE queue message width.
REQ-003 The block SHALL have port clk_i, input, width 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n_i, input, width 1: reset, asynchronous and active-low.
REQ-005 The block SHALL have port clr_i, input, width 1: flush of all entries (FE redirect).
REQ-006 The block SHALL have port data_i, input, width width_p: enqueue message.
REQ-007 The block SHALL have port v_i, input, width 1: enqueue valid.
REQ-008 The block SHALL have port ready_o, output, width 1: enqueue accepted this cycle when v_i is also high.
REQ-009 The block SHALL have port data_o, output, width width_p: message at the speculative read pointer.
REQ-010 The block SHALL have port v_o, output, width 1: data_o valid.
REQ-011 The block SHALL have port yumi_i, input, width 1: consumer takes data_o; advances the speculative read pointer.
REQ-012 The block SHALL have port deq_i, input, width 1: commit of the oldest issued entry; frees it.
REQ-013 The block SHALL have port roll_i, input, width 1: rewind the speculative read pointer to the committed pointer.
REQ-014 The block SHALL have port empty_o, output, width 1: no uncommitted entries held.

Function
REQ-015 The block SHALL keep three pointers, wptr, rptr and cptr, each $clog2(els_p)+1 bits wide; the MSB is a wrap bit, and the pointers increment modulo 2*els_p.
REQ-016 Occupancy SHALL equal wptr-cptr, computed modulo 2*els_p; full means occupancy==els_p.
- ready_o = ~full & ~clr_i.
- Entries between cptr and rptr (issued but uncommitted) count toward full.
REQ-017 An enqueue SHALL occur when v_i & ready_o: mem[wptr] <= data_i and wptr increments.
REQ-018 When v_i is high and ready_o is low, data_i SHALL be dropped with no state change; the producer holds it.
REQ-019 v_o SHALL be high iff rptr!=wptr, and data_o = mem[rptr[low bits]]; there is no write-to-read bypass.
- Enqueue-to-visible latency is 1 cycle.
- data_o is don't-care when v_o is low.
REQ-020 yumi_i SHALL advance rptr by 1; the consumer only asserts yumi_i while v_o is high.
REQ-021 deq_i SHALL advance cptr by 1; the consumer only asserts deq_i while cptr!=rptr.
REQ-022 roll_i SHALL set rptr <= cptr; yumi_i and deq_i in the same cycle are ignored.
- Enqueue in the same cycle still proceeds.
REQ-023 clr_i SHALL set wptr, rptr and cptr to the value wptr+1 would have had, without writing mem.
- Concurrent v_i, yumi_i, deq_i and roll_i are ignored.
- Priority: clr_i > roll_i > (yumi_i, deq_i, enqueue).
REQ-024 Simultaneous enqueue, yumi_i and deq_i SHALL all take effect in the same cycle.
REQ-025 Enqueue when occupancy==els_p-1 SHALL make ready_o low in the next cycle.
- deq_i and enqueue in the same cycle while full is impossible, because ready_o is low.
REQ-026 empty_o SHALL be high iff wptr==cptr.
REQ-027 Simulation assertions SHALL flag yumi_i & ~v_o, deq_i when cptr==rptr, and (roll_i|clr_i) while reset is asserted.

Reset
REQ-028 While reset_n_i is low, all three pointers SHALL be 0 immediately (asynchronously), giving ready_o=1, v_o=0 and empty_o=1.
REQ-029 mem SHALL NOT be reset.
REQ-030 Reset release SHALL be synchronized externally; the block is usable on the first rising edge after deassertion.
REQ-031 Reset asserted mid-operation SHALL discard all entries, including issued but uncommitted ones.

Verification
REQ-032 Basic flow: enqueue A,B,C on consecutive cycles, then yumi_i each -> data_o shows A,B,C in order, starting 1 cycle after A; v_o falls after C.
REQ-033 Full: els_p=8; enqueue 8 entries, yumi_i all 8 without deq_i -> ready_o=0, v_o=0; one deq_i -> ready_o=1 the next cycle.
REQ-034 Roll: enqueue A..E, yumi_i A,B,C, deq_i A, then roll_i -> data_o=B next cycle; B and C are re-read; wptr is unchanged.
REQ-035 Priority: assert roll_i, deq_i and yumi_i together with an enqueue of D -> rptr=cptr, cptr unchanged, D stored.
- A later clr_i together with v_i -> empty_o=1, v_o=0, D' not stored.
REQ-036 Wrap: run 3*els_p+3 enqueue/yumi/deq triples continuously -> no data corruption, and ready_o never drops.
REQ-037 Async reset: drop reset_n_i between clock edges while 5 entries are held -> v_o=0, empty_o=1 and ready_o=1 before the next edge.
